avg_ram_reader: RTL
===================

// Module: avg_ram_reader
// PURPOSE
//  Read side of the averaged-sample RAM. The averager writes one 8-bit average per
//  four input samples. This block reads a block of those averages back, from a base
//  address for a programmed word count, over the RAM's registered read port. It
//  presents each word on a valid/ready byte stream to the downstream consumer.
//  - FSM-driven.
//  - Single RAM read outstanding at a time.
// PARAMETERS
//  ADDR_W  8  RAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  8  RAM word / output data width (matches averager ram_data)
// PORTS
//  clk_2       in   1        single clock; all logic on posedge
//  reset       in   1        synchronous, active-high reset
//  start       in   1        begin a block read; sampled only in IDLE
//  abort       in   1        cancel the current block; sampled in every non-IDLE state
//  base_addr   in   ADDR_W   first RAM address, captured when start accepted
//  count       in   ADDR_W+1 words to read (0..2**ADDR_W), captured with base_addr
//  ram_rd      out  1        RAM read strobe, one cycle per word
//  ram_addr    out  ADDR_W   RAM read address, valid while ram_rd=1
//  ram_q       in   DATA_W   RAM read data, valid the cycle after ram_rd (1-cycle latency)
//  out_data    out  DATA_W   stream data
//  out_valid   out  1        stream valid
//  out_ready   in   1        stream ready from consumer
//  busy        out  1        high in any state other than IDLE
//  done        out  1        one-cycle pulse after the last word of a block is accepted
// BEHAVIOUR
//  - Reset (reset=1 at posedge, in any state):
//    - FSM->IDLE.
//    - ram_rd=0, ram_addr=0, out_data=0, out_valid=0, busy=0, done=0.
//    - Address and remaining-count registers are cleared.
//  - States and transitions:
//    - IDLE: start=1 captures base_addr/count.
//      - count=0 -> DONE.
//      - otherwise -> FETCH.
//    - FETCH (1 cycle): ram_rd=1, ram_addr=current address -> CAPTURE.
//    - CAPTURE (1 cycle): ram_q registered into out_data; remaining decremented;
//      address incremented modulo 2**ADDR_W -> HOLD.
//    - HOLD: out_valid=1.
//      - On out_valid & out_ready: remaining>0 -> FETCH; remaining=0 -> DONE.
//    - DONE (1 cycle): done=1 -> IDLE.
//  - Latency: start high in cycle 0 -> ram_rd in cycle 1 -> ram_q sampled in cycle 2
//    -> out_valid in cycle 3. With out_ready held at 1, throughput is one word per
//    3 cycles.
//  - Stream rules:
//    - out_data is held stable while out_valid=1 and out_ready=0.
//    - out_valid never drops without a handshake, except on abort or reset.
//    - out_ready is ignored when out_valid=0.
//  - start while busy is ignored; the captured parameters are not altered.
//  - Abort:
//    - Any non-IDLE state -> IDLE on the next edge.
//    - out_valid and ram_rd are 0 from that edge; done is not pulsed.
//    - Abort in DONE still lets done complete.
//    - abort has priority over a same-cycle handshake.
//  - Simultaneous reset and abort: reset wins; the results are identical.
//  - count=2**ADDR_W reads every location exactly once, wrapping past the top address.
// TESTING
//  1. reset, base_addr=8'h10, count=3, RAM[10..12]=8'h11,22,33, out_ready=1, start pulse
//     -> ram_rd in cycles 1, 4, 7; out 11,22,33 valid in cycles 3, 6, 9;
//     done in cycle 10; busy=0 from cycle 11.
//  2. Same block, out_ready=0 for 5 cycles on word 2 -> out_data=8'h22 held stable,
//     no extra ram_rd, stream order unchanged.
//  3. base_addr=8'hFE, count=4 -> ram_addr sequence FE, FF, 00, 01.
//  4. count=0 with a start pulse -> no ram_rd, no out_valid; done 1 cycle after start.
//  5. abort while in HOLD with out_ready=1 -> no handshake counted; out_valid=0 next cycle;
//     no done pulse; a new start is accepted the cycle after.
//  6. reset asserted mid-block during CAPTURE -> all outputs 0 next edge; start ignored
//     while reset=1.

Source files
------------

// File: rtl/avg_ram_reader.sv
// avg_ram_reader
//   Reads a block of averaged samples back out of the averager RAM and hands
//   them to a downstream consumer over a valid/ready byte stream. One RAM read
//   is in flight at a time: FETCH issues the strobe, CAPTURE registers the
//   returned word, HOLD presents it until the consumer takes it.
//
// Ports
//   clk_2      : single clock, all logic on posedge
//   reset      : synchronous, active-high
//   start      : begin a block read (only looked at in IDLE)
//   abort      : cancel the block (looked at in every non-IDLE state)
//   base_addr  : first RAM address, captured on accepted start
//   count      : number of words to read (0 .. 2**ADDR_W), captured with base
//   ram_rd     : read strobe, one cycle per word
//   ram_addr   : read address, meaningful while ram_rd=1
//   ram_q      : read data, valid the cycle after ram_rd
//   out_data   : stream data
//   out_valid  : stream valid
//   out_ready  : stream ready
//   busy       : high in any state other than IDLE
//   done       : one-cycle pulse after the last word of a block is accepted
module avg_ram_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;     // next RAM address to fetch
  logic [ADDR_W:0]     rem_q, rem_d;       // words still to be captured
  logic                ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next state and datapath.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = count;
          state_d = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d = ram_q;
        rem_d      = rem_q - 1'b1;
        addr_d     = addr_q + 1'b1;  // wraps modulo 2**ADDR_W
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        // out_valid is high for the whole of HOLD, so ready alone is the handshake.
        if (out_ready)
          state_d = (rem_q == '0) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats any same-cycle handshake; in DONE it lands in IDLE anyway,
    // so the done pulse already on the output is unaffected.
    if (abort && (state_q != S_IDLE))
      state_d = S_IDLE;
  end

  // Outputs are decoded from the next state so they are flop outputs aligned
  // with the state they belong to.
  always_comb begin
    ram_rd_d    = (state_d == S_FETCH);
    ram_addr_d  = (state_d == S_FETCH) ? addr_d : ram_addr_q;
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      ram_rd_q    <= 1'b0;
      ram_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ram_rd_q    <= ram_rd_d;
      ram_addr_q  <= ram_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_rd    = ram_rd_q;
  assign ram_addr  = ram_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
